// File: rtl/lfsr_generator.sv
// lfsr_generator: 8-bit Galois LFSR pattern source with optional error-burst injection.
//
// The LFSR includes the all-zero state, so it walks all 256 values. Each word is
// registered onto o_LFSR with o_valid for a downstream pattern checker.
//
// Optional feature macro: LFSR_GEN_ERR_INJ_EN
//   defined   -> INJECT state, burst counter and mask latch are built; a request
//                corrupts the next i_inj_len valid words with i_inj_mask.
//   undefined -> i_inj_req/i_inj_len/i_inj_mask are ignored, o_inj_active is 0.
//
// Ports:
//   clk           rising-edge clock
//   i_reset       asynchronous, active-high reset
//   i_enable      run/advance request
//   i_seed_load   synchronous seed load strobe (highest priority)
//   i_seed        seed value captured on i_seed_load
//   i_inj_req     error-burst request pulse
//   i_inj_len     number of words to corrupt (0 = no burst)
//   i_inj_mask    XOR mask applied to corrupted words
//   o_LFSR        registered generated word
//   o_valid       o_LFSR holds a new word this cycle
//   o_inj_active  current valid o_LFSR word is corrupted
//   o_word_cnt    count of words emitted with o_valid high (wraps)
module lfsr_generator #(
    parameter logic [7:0] SEED_DEFAULT = 8'h01
) (
    input  logic        clk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic        i_seed_load,
    input  logic [7:0]  i_seed,
    input  logic        i_inj_req,
    input  logic [2:0]  i_inj_len,
    input  logic [7:0]  i_inj_mask,
    output logic [7:0]  o_LFSR,
    output logic        o_valid,
    output logic        o_inj_active,
    output logic [15:0] o_word_cnt
);

    localparam int unsigned LFSR_W = 8;
    localparam int unsigned CNT_W  = 16;
`ifdef LFSR_GEN_ERR_INJ_EN
    localparam int unsigned LEN_W  = 3;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1
`ifdef LFSR_GEN_ERR_INJ_EN
        ,
        INJECT = 2'd2
`endif
    } state_t;

    state_t              state_q;
    logic [LFSR_W-1:0]   lfsr_q;
    logic [LFSR_W-1:0]   lfsr_d;
    logic [LFSR_W-1:0]   word_q;
    logic                valid_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                fb_c;

`ifdef LFSR_GEN_ERR_INJ_EN
    logic [LEN_W-1:0]    burst_q;
    logic [LFSR_W-1:0]   mask_q;
    logic                inj_q;
`else
    logic                unused_inj_c;
    assign unused_inj_c = ^{i_inj_req, i_inj_len, i_inj_mask};
`endif

    // Feedback with the zero-state insertion term: forces the 0x80 -> 0x00 -> 0x8D detour
    assign fb_c   = lfsr_q[7] ^ (lfsr_q[6:0] == 7'd0);
    assign lfsr_d = {lfsr_q[6] ^ fb_c, lfsr_q[5], lfsr_q[4], lfsr_q[3],
                     lfsr_q[2] ^ fb_c, lfsr_q[1] ^ fb_c, lfsr_q[0], fb_c};

    // Control FSM, LFSR state, output word and word counter
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= IDLE;
            lfsr_q  <= SEED_DEFAULT;
            word_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
`ifdef LFSR_GEN_ERR_INJ_EN
            burst_q <= '0;
            mask_q  <= '0;
            inj_q   <= 1'b0;
`endif
        end else if (i_seed_load) begin
            // Seed load aborts everything except the word counter
            state_q <= IDLE;
            lfsr_q  <= i_seed;
            valid_q <= 1'b0;
`ifdef LFSR_GEN_ERR_INJ_EN
            burst_q <= '0;
            mask_q  <= '0;
            inj_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
`ifdef LFSR_GEN_ERR_INJ_EN
                    inj_q   <= 1'b0;
`endif
                    if (i_enable) begin
                        state_q <= RUN;
                    end
                end

                RUN: begin
`ifdef LFSR_GEN_ERR_INJ_EN
                    inj_q <= 1'b0;
`endif
                    if (i_enable) begin
                        word_q  <= lfsr_q;
                        valid_q <= 1'b1;
                        lfsr_q  <= lfsr_d;
                        cnt_q   <= cnt_q + CNT_W'(1);
`ifdef LFSR_GEN_ERR_INJ_EN
                        // Current word goes out clean; the burst starts with the next one
                        if (i_inj_req && (i_inj_len != '0)) begin
                            burst_q <= i_inj_len;
                            mask_q  <= i_inj_mask;
                            state_q <= INJECT;
                        end
`endif
                    end else begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end

`ifdef LFSR_GEN_ERR_INJ_EN
                INJECT: begin
                    if (i_enable) begin
                        word_q  <= lfsr_q ^ mask_q;
                        valid_q <= 1'b1;
                        inj_q   <= 1'b1;
                        lfsr_q  <= lfsr_d;
                        cnt_q   <= cnt_q + CNT_W'(1);
                        burst_q <= burst_q - LEN_W'(1);
                        if (burst_q == LEN_W'(1)) begin
                            state_q <= RUN;
                        end
                    end else begin
                        // Paused: burst position and LFSR are frozen
                        valid_q <= 1'b0;
                        inj_q   <= 1'b0;
                    end
                end
`endif

                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_LFSR     = word_q;
    assign o_valid    = valid_q;
    assign o_word_cnt = cnt_q;

`ifdef LFSR_GEN_ERR_INJ_EN
    assign o_inj_active = inj_q;
`else
    assign o_inj_active = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_generator.sv
// tb_lfsr_generator: self-checking bench for lfsr_generator against a behavioural model.
// Follows LFSR_GEN_ERR_INJ_EN the same way the design does.
module tb_lfsr_generator;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_enable;
    logic        i_seed_load;
    logic [7:0]  i_seed;
    logic        i_inj_req;
    logic [2:0]  i_inj_len;
    logic [7:0]  i_inj_mask;
    logic [7:0]  o_LFSR;
    logic        o_valid;
    logic        o_inj_active;
    logic [15:0] o_word_cnt;

    int checks = 0;
    int passes = 0;

`ifdef LFSR_GEN_ERR_INJ_EN
    localparam bit INJ_BUILT = 1'b1;
`else
    localparam bit INJ_BUILT = 1'b0;
`endif

    // Reference model state
    logic [7:0]  m_L;
    bit          m_active;
    int          m_burst;
    logic [7:0]  m_mask;
    logic [7:0]  exp_lfsr;
    logic        exp_valid;
    logic        exp_inj;
    logic [15:0] exp_cnt;

    always #5 clk = ~clk;

    lfsr_generator #(.SEED_DEFAULT(8'h01)) dut (
        .clk          (clk),
        .i_reset      (i_reset),
        .i_enable     (i_enable),
        .i_seed_load  (i_seed_load),
        .i_seed       (i_seed),
        .i_inj_req    (i_inj_req),
        .i_inj_len    (i_inj_len),
        .i_inj_mask   (i_inj_mask),
        .o_LFSR       (o_LFSR),
        .o_valid      (o_valid),
        .o_inj_active (o_inj_active),
        .o_word_cnt   (o_word_cnt)
    );

    // Multiply by x modulo the feedback polynomial, with the de Bruijn zero-state fix-up
    function automatic logic [7:0] ref_next(input logic [7:0] v);
        logic fb;
        fb = v[7] ^ (v[6:0] == 7'd0);
        return {v[6:0], 1'b0} ^ (fb ? 8'h8D : 8'h00);
    endfunction

    task automatic model_reset();
        m_L = 8'h01; m_active = 0; m_burst = 0; m_mask = 8'h00;
        exp_lfsr = 8'h00; exp_valid = 1'b0; exp_inj = 1'b0; exp_cnt = 16'h0000;
    endtask

    // One clock edge of intended behaviour, using the inputs present at that edge
    task automatic model_edge();
        if (i_seed_load) begin
            m_L = i_seed; m_active = 0; m_burst = 0;
            exp_valid = 1'b0; exp_inj = 1'b0;
        end else if (!m_active) begin
            exp_valid = 1'b0; exp_inj = 1'b0;
            if (i_enable) m_active = 1;
        end else if (!i_enable) begin
            exp_valid = 1'b0; exp_inj = 1'b0;
            if (m_burst == 0) m_active = 0;
        end else begin
            exp_valid = 1'b1;
            exp_cnt   = exp_cnt + 16'd1;
            if (m_burst > 0) begin
                exp_lfsr = m_L ^ m_mask;
                exp_inj  = 1'b1;
                m_burst--;
            end else begin
                exp_lfsr = m_L;
                exp_inj  = 1'b0;
                if (INJ_BUILT && i_inj_req && i_inj_len != 3'd0) begin
                    m_burst = int'(i_inj_len);
                    m_mask  = i_inj_mask;
                end
            end
            m_L = ref_next(m_L);
        end
    endtask

    task automatic step_clk();
        @(posedge clk);
        if (!i_reset) model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_enable = 1'b0; i_seed_load = 1'b0; i_seed = 8'h00;
        i_inj_req = 1'b0; i_inj_len = 3'd0; i_inj_mask = 8'h00;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (o_LFSR !== 8'h00 || o_valid !== 1'b0 || o_inj_active !== 1'b0 || o_word_cnt !== 16'h0000)
            $display("FAIL reset_async: got lfsr=%h valid=%b inj=%b cnt=%h want 00/0/0/0000",
                     o_LFSR, o_valid, o_inj_active, o_word_cnt);
        else passes++;
        @(negedge clk);
        i_reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        // Held-off enable: nothing must come out while idle
        step_clk();
        checks++;
        if (o_valid !== 1'b0 || o_word_cnt !== 16'h0000 || o_LFSR !== 8'h00)
            $display("FAIL reset_idle: got valid=%b cnt=%h lfsr=%h want 0/0000/00", o_valid, o_word_cnt, o_LFSR);
        else passes++;
    endtask

    task automatic test_basic_sequence();
        logic [7:0] golden [0:10];
        int k;
        int first_edge;
        golden = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h00, 8'h8D, 8'h97};
        k = 0;
        first_edge = -1;
        i_enable = 1'b1;
        for (int e = 1; e <= 13; e++) begin
            step_clk();
            checks++;
            if (o_LFSR !== exp_lfsr || o_valid !== exp_valid || o_inj_active !== exp_inj || o_word_cnt !== exp_cnt)
                $display("FAIL basic_model edge %0d: got %h/%b/%b/%h want %h/%b/%b/%h", e,
                         o_LFSR, o_valid, o_inj_active, o_word_cnt, exp_lfsr, exp_valid, exp_inj, exp_cnt);
            else passes++;
            if (o_valid === 1'b1) begin
                if (first_edge < 0) first_edge = e;
                if (k < 11) begin
                    checks++;
                    if (o_LFSR !== golden[k])
                        $display("FAIL basic_golden word %0d: got %h want %h", k, o_LFSR, golden[k]);
                    else passes++;
                    k++;
                end
            end
        end
        checks++;
        if (first_edge != 2 || k != 11)
            $display("FAIL basic_latency: first valid edge %0d words %0d want 2 and 11", first_edge, k);
        else passes++;
    endtask

    task automatic test_seed_load();
        logic [7:0] seen [$];
        i_enable = 1'b1;
        step_clk();
        i_seed_load = 1'b1; i_seed = 8'h8D;
        step_clk();
        i_seed_load = 1'b0; i_seed = 8'h00;
        checks++;
        if (o_valid !== 1'b0 || o_word_cnt !== exp_cnt)
            $display("FAIL seed_load_stop: got valid=%b cnt=%h want 0/%h", o_valid, o_word_cnt, exp_cnt);
        else passes++;
        for (int e = 0; e < 5; e++) begin
            step_clk();
            checks++;
            if (o_LFSR !== exp_lfsr || o_valid !== exp_valid || o_word_cnt !== exp_cnt)
                $display("FAIL seed_model edge %0d: got %h/%b/%h want %h/%b/%h", e,
                         o_LFSR, o_valid, o_word_cnt, exp_lfsr, exp_valid, exp_cnt);
            else passes++;
            if (o_valid === 1'b1) seen.push_back(o_LFSR);
        end
        checks++;
        if (seen.size() < 2 || seen[0] !== 8'h8D || seen[1] !== 8'h97)
            $display("FAIL seed_restart: got %0d words first %h %h want 8d 97", seen.size(),
                     (seen.size() > 0) ? seen[0] : 8'hxx, (seen.size() > 1) ? seen[1] : 8'hxx);
        else passes++;
    endtask

`ifdef LFSR_GEN_ERR_INJ_EN
    task automatic test_inject();
        int n_inj;
        int relock;
        logic [7:0] prev;
        bit have_prev;
        n_inj = 0; relock = 0; have_prev = 0; prev = 8'h00;
        i_enable = 1'b1;
        step_clk();
        i_inj_req = 1'b1; i_inj_len = 3'd3; i_inj_mask = 8'h01;
        step_clk();
        i_inj_req = 1'b0; i_inj_len = 3'd0; i_inj_mask = 8'h00;
        checks++;
        if (o_inj_active !== 1'b0 || o_valid !== 1'b1)
            $display("FAIL inj_trigger_word: got valid=%b inj=%b want 1/0", o_valid, o_inj_active);
        else passes++;
        for (int e = 0; e < 8; e++) begin
            // Retrigger attempt mid-burst must be ignored
            i_inj_req = (e == 1); i_inj_len = 3'd7; i_inj_mask = 8'hFF;
            step_clk();
            checks++;
            if (o_LFSR !== exp_lfsr || o_valid !== exp_valid || o_inj_active !== exp_inj || o_word_cnt !== exp_cnt)
                $display("FAIL inj_model edge %0d: got %h/%b/%b/%h want %h/%b/%b/%h", e,
                         o_LFSR, o_valid, o_inj_active, o_word_cnt, exp_lfsr, exp_valid, exp_inj, exp_cnt);
            else passes++;
            if (o_valid === 1'b1 && o_inj_active === 1'b1) n_inj++;
            // A checker relocks once consecutive clean words follow the LFSR rule again
            if (o_valid === 1'b1 && o_inj_active === 1'b0 && have_prev && o_LFSR === ref_next(prev)) relock++;
            have_prev = (o_valid === 1'b1 && o_inj_active === 1'b0);
            prev = o_LFSR;
        end
        i_inj_req = 1'b0; i_inj_len = 3'd0; i_inj_mask = 8'h00;
        checks++;
        if (n_inj != 3 || relock < 2)
            $display("FAIL inj_burst_len: got %0d corrupted words relock %0d want 3 and >=2", n_inj, relock);
        else passes++;
    endtask

    task automatic test_inject_pause();
        int n_inj;
        logic [15:0] held_cnt;
        n_inj = 0;
        i_enable = 1'b1;
        i_inj_req = 1'b1; i_inj_len = 3'd4; i_inj_mask = 8'hA5;
        step_clk();
        i_inj_req = 1'b0; i_inj_len = 3'd0; i_inj_mask = 8'h00;
        step_clk();
        if (o_inj_active === 1'b1) n_inj++;
        held_cnt = exp_cnt;
        i_enable = 1'b0;
        for (int e = 0; e < 3; e++) begin
            step_clk();
            checks++;
            if (o_valid !== 1'b0 || o_inj_active !== 1'b0 || o_word_cnt !== held_cnt)
                $display("FAIL inj_pause edge %0d: got valid=%b inj=%b cnt=%h want 0/0/%h", e,
                         o_valid, o_inj_active, o_word_cnt, held_cnt);
            else passes++;
        end
        i_enable = 1'b1;
        for (int e = 0; e < 5; e++) begin
            step_clk();
            checks++;
            if (o_LFSR !== exp_lfsr || o_valid !== exp_valid || o_inj_active !== exp_inj || o_word_cnt !== exp_cnt)
                $display("FAIL inj_resume edge %0d: got %h/%b/%b/%h want %h/%b/%b/%h", e,
                         o_LFSR, o_valid, o_inj_active, o_word_cnt, exp_lfsr, exp_valid, exp_inj, exp_cnt);
            else passes++;
            if (o_valid === 1'b1 && o_inj_active === 1'b1) n_inj++;
        end
        checks++;
        if (n_inj != 4)
            $display("FAIL inj_pause_total: got %0d corrupted words want 4", n_inj);
        else passes++;
    endtask
`else
    task automatic test_inject_ignored();
        i_enable = 1'b1;
        for (int e = 0; e < 12; e++) begin
            i_inj_req = (e % 3 == 0); i_inj_len = 3'd5; i_inj_mask = 8'hFF;
            step_clk();
            checks++;
            if (o_LFSR !== exp_lfsr || o_valid !== exp_valid || o_inj_active !== 1'b0 || o_word_cnt !== exp_cnt)
                $display("FAIL inj_ignored edge %0d: got %h/%b/%b/%h want %h/%b/0/%h", e,
                         o_LFSR, o_valid, o_inj_active, o_word_cnt, exp_lfsr, exp_valid, exp_cnt);
            else passes++;
        end
        i_inj_req = 1'b0; i_inj_len = 3'd0; i_inj_mask = 8'h00;
    endtask
`endif

    task automatic test_reset_mid_burst();
        int n_inj;
        n_inj = 0;
        i_enable = 1'b1;
        i_inj_req = 1'b1; i_inj_len = 3'd7; i_inj_mask = 8'h3C;
        step_clk();
        i_inj_req = 1'b0; i_inj_len = 3'd0; i_inj_mask = 8'h00;
        step_clk();
        step_clk();
        do_reset();
        i_enable = 1'b1;
        for (int e = 0; e < 10; e++) begin
            step_clk();
            checks++;
            if (o_LFSR !== exp_lfsr || o_valid !== exp_valid || o_inj_active !== exp_inj || o_word_cnt !== exp_cnt)
                $display("FAIL rst_burst edge %0d: got %h/%b/%b/%h want %h/%b/%b/%h", e,
                         o_LFSR, o_valid, o_inj_active, o_word_cnt, exp_lfsr, exp_valid, exp_inj, exp_cnt);
            else passes++;
            if (o_inj_active === 1'b1) n_inj++;
        end
        checks++;
        if (n_inj != 0)
            $display("FAIL rst_burst_clean: got %0d corrupted words after reset want 0", n_inj);
        else passes++;
    endtask

    task automatic test_random();
        for (int e = 0; e < 400; e++) begin
            i_enable    = ($urandom_range(0, 9) != 0);
            i_seed_load = ($urandom_range(0, 29) == 0);
            i_seed      = 8'($urandom);
            i_inj_req   = ($urandom_range(0, 7) == 0);
            i_inj_len   = 3'($urandom);
            i_inj_mask  = 8'($urandom);
            step_clk();
            checks++;
            if (o_LFSR !== exp_lfsr || o_valid !== exp_valid || o_inj_active !== exp_inj || o_word_cnt !== exp_cnt)
                $display("FAIL random edge %0d: got %h/%b/%b/%h want %h/%b/%b/%h", e,
                         o_LFSR, o_valid, o_inj_active, o_word_cnt, exp_lfsr, exp_valid, exp_inj, exp_cnt);
            else passes++;
        end
        idle_inputs();
    endtask

    task automatic test_wrap_period();
        int words;
        int period;
        int budget;
        logic [7:0] first_w;
        words = 0; period = 0; budget = 0; first_w = 8'h00;
        do_reset();
        i_enable = 1'b1;
        while (words < 65541 && budget < 70000) begin
            step_clk();
            budget++;
            if (o_valid === 1'b1) begin
                if (words == 0) first_w = o_LFSR;
                else if (period == 0 && o_LFSR === first_w) period = words;
                words++;
            end
        end
        i_enable = 1'b0;
        checks++;
        if (words != 65541)
            $display("FAIL wrap_budget: got %0d words within %0d edges want 65541", words, budget);
        else passes++;
        checks++;
        if (o_word_cnt !== 16'd5 || o_word_cnt !== exp_cnt)
            $display("FAIL wrap_count: got %h want 0005 (model %h)", o_word_cnt, exp_cnt);
        else passes++;
        checks++;
        if (period != 256)
            $display("FAIL period: got %0d want 256", period);
        else passes++;
        checks++;
        if (o_LFSR !== exp_lfsr)
            $display("FAIL wrap_word: got %h want %h", o_LFSR, exp_lfsr);
        else passes++;
    endtask

    initial begin
        idle_inputs();
        i_reset = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_basic_sequence();
        test_seed_load();
`ifdef LFSR_GEN_ERR_INJ_EN
        test_inject();
        test_inject_pause();
`else
        test_inject_ignored();
`endif
        test_reset_mid_burst();
        test_random();
        test_wrap_period();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/lfsr_generator.md
LFSR_GENERATOR -- requirements
Module: lfsr_generator

Interface
REQ-001 SHALL provide parameter SEED_DEFAULT, default 8'h01, the LFSR state loaded at reset.
REQ-002 SHALL provide port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 SHALL provide port i_reset, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL provide port i_enable, input, 1 bit: run/advance request.
REQ-005 SHALL provide port i_seed_load, input, 1 bit: synchronous seed load strobe.
REQ-006 SHALL provide port i_seed, input, 8 bits: seed value captured on i_seed_load.
REQ-007 SHALL provide port i_inj_req, input, 1 bit: error-burst request pulse.
REQ-008 SHALL provide port i_inj_len, input, 3 bits: number of words to corrupt.
REQ-009 SHALL provide port i_inj_mask, input, 8 bits: XOR mask applied to corrupted words.
REQ-010 SHALL provide port o_LFSR, output, 8 bits: registered generated word, feeding the downstream checker i_LFSR.
REQ-011 SHALL provide port o_valid, output, 1 bit: o_LFSR holds a new word this cycle; feeds checker i_valid.
REQ-012 SHALL provide port o_inj_active, output, 1 bit: current o_LFSR word is corrupted.
REQ-013 SHALL provide port o_word_cnt, output, 16 bits: count of words emitted with o_valid high.

Function
REQ-014 SHALL use an 8-bit Galois LFSR with fb = L[7] ^ (L[6:0]==0): next = {L[6]^fb, L[5], L[4], L[3], L[2]^fb, L[1]^fb, L[0], fb}, giving a 256-state sequence that includes 8'h00.
REQ-015 SHALL implement an FSM with states IDLE, RUN and INJECT.
REQ-016 SHALL, in IDLE, keep o_valid at 0, hold the LFSR, and go to RUN on the edge where i_enable=1.
REQ-017 SHALL, in RUN or INJECT with i_enable=1, per edge: register o_LFSR <= LFSR (XOR latched mask in INJECT), set o_valid=1, advance the LFSR, and increment o_word_cnt.
REQ-018 SHALL make the first o_valid appear 2 edges after i_enable rises in IDLE.
REQ-019 SHALL, in RUN with i_enable=0, go to IDLE and set o_valid=0 on the next edge.
REQ-020 SHALL, in INJECT with i_enable=0, stay in INJECT, set o_valid=0, and freeze the LFSR and the burst counter.
REQ-021 SHALL, in RUN with i_enable=1, i_inj_req=1 and i_inj_len!=0, latch i_inj_len and i_inj_mask and enter INJECT; the current word is emitted uncorrupted and the next i_inj_len valid words are corrupted.
REQ-022 SHALL ignore i_inj_req when i_inj_len=0, and shall ignore it when already in INJECT (no retrigger).
REQ-023 SHALL decrement the burst counter once per corrupted word and return to RUN after the word where the counter reaches 1.
REQ-024 SHALL drive o_inj_active=1 exactly when the o_LFSR word with o_valid=1 was corrupted, and 0 otherwise.
REQ-025 SHALL give i_seed_load the highest priority over all other inputs: LFSR <= i_seed, state <= IDLE, o_valid <= 0, burst aborted; o_word_cnt is unchanged.
REQ-026 SHALL let o_word_cnt wrap from 16'hFFFF to 16'h0000.

Reset
REQ-027 SHALL, on i_reset, immediately set LFSR=SEED_DEFAULT, state=IDLE, o_LFSR=8'h00, o_valid=0, o_inj_active=0, o_word_cnt=0, burst counter=0 and latched mask=0.
REQ-028 SHALL, when reset is asserted mid-burst, abort the burst, and emit no corrupted word after reset release.

Configuration
REQ-029 SHALL, with macro LFSR_GEN_ERR_INJ_EN defined, compile in the INJECT state, the burst counter and the mask latch per REQ-021..024.
REQ-030 SHALL, without LFSR_GEN_ERR_INJ_EN, omit INJECT, ignore i_inj_req/i_inj_len/i_inj_mask, and tie o_inj_active to 0.

Verification
REQ-031 SHALL cover: reset, then i_enable held at 1 -> o_valid high from edge 2; o_LFSR = 01,02,04,08,10,20,40,80,00,8D,97.
REQ-032 SHALL cover: i_seed_load with i_seed=8'h8D while running -> o_valid=0 for one edge, IDLE; re-enable -> 8D,97 sequence.
REQ-033 SHALL cover: macro defined, i_inj_req with len=3 and mask=8'h01 -> next 3 valid words are bit0-inverted with o_inj_active=1, then clean words; checker lock drops, then relocks.
REQ-034 SHALL cover: i_enable toggled 0 during INJECT -> no words, burst count preserved, remaining corrupted words continue on re-enable.
REQ-035 SHALL cover: 65536+5 words emitted -> o_word_cnt=5; sequence period measured as 256.
REQ-036 SHALL cover: macro undefined, i_inj_req pulsed -> output identical to an uncorrupted run, o_inj_active constantly 0.
